// File: rtl/dense_pkg.sv
// dense_pkg: shared state encoding, coefficient address width and output rounding/saturation.
package dense_pkg;

    typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_e;

    function automatic int coef_aw(input int n_out, input int n_in);
        return (n_out * (n_in + 1) > 1) ? $clog2(n_out * (n_in + 1)) : 1;
    endfunction

    // Operands arrive sign-extended to 64 bits so one function serves every parameterisation.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input logic signed [63:0] bias,
        input int                 frac_w,
        input int                 data_w,
        input bit                 relu
    );
        logic signed [63:0] r, hi, lo;
        r  = (acc + (bias <<< frac_w) + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (relu && r < 0)
            r = '0;
        return (r > hi) ? hi : (r < lo) ? lo : r;
    endfunction

endpackage

// File: rtl/dense_coef_ram.sv
// dense_coef_ram: weight/bias store, synchronous write and asynchronous read.
module dense_coef_ram #(
    parameter int DEPTH  = 17,
    parameter int AW     = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we_i)
            mem[waddr_i] <= wdata_i;

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dense_output_layer.sv
// dense_output_layer: serial single-MAC fully-connected output stage with programmable
// coefficients, round-half-up and saturation, valid/ready result handshake.
module dense_output_layer
    import dense_pkg::*;
#(
    parameter  int N_IN    = 16,
    parameter  int N_OUT   = 1,
    parameter  int DATA_W  = 16,
    parameter  int FRAC_W  = 8,
    parameter  int ACC_W   = 40,
    parameter  int RELU_EN = 0,
    localparam int AW      = coef_aw(N_OUT, N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*DATA_W-1:0]  input_data,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [DATA_W-1:0]       cfg_data,
    output logic                    cfg_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT*DATA_W-1:0] final_output,
    output logic                    busy
);

    localparam int DEPTH = N_OUT * (N_IN + 1);
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] x_q [N_IN];
    logic signed [DATA_W-1:0] x_d [N_IN];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IW-1:0]            i_q, i_d;
    logic [OW-1:0]            o_q, o_d;
    logic [N_OUT*DATA_W-1:0]  out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     cfg_err_q, cfg_err_d;
    logic signed [DATA_W-1:0] coef;
    logic signed [2*DATA_W-1:0] prod;
    logic [AW-1:0]            rd_addr;
    logic                     cfg_ok;

    assign cfg_ok  = cfg_we && state_q == IDLE && 32'(cfg_addr) < DEPTH;
    // The single read port serves the weight during MAC and the bias during FIN.
    assign rd_addr = AW'(32'(o_q) * (N_IN + 1) + ((state_q == FIN) ? N_IN : 32'(i_q)));
    assign prod    = x_q[i_q] * coef;

    dense_coef_ram #(.DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .we_i    (cfg_ok),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_data),
        .raddr_i (rd_addr),
        .rdata_o (coef)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        acc_d       = acc_q;
        i_d         = i_q;
        o_d         = o_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cfg_err_d   = cfg_we && !cfg_ok;
        case (state_q)
            IDLE: if (in_valid) begin
                for (int k = 0; k < N_IN; k++)
                    x_d[k] = input_data[k*DATA_W +: DATA_W];
                acc_d   = '0;
                i_d     = '0;
                o_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = acc_q + ACC_W'(prod);
                i_d     = (i_q == IW'(N_IN - 1)) ? '0 : i_q + 1'b1;
                state_d = (i_q == IW'(N_IN - 1)) ? FIN : MAC;
            end
            FIN: begin
                out_d[32'(o_q)*DATA_W +: DATA_W] =
                    DATA_W'(sat_round(64'(acc_q), 64'(coef), FRAC_W, DATA_W, RELU_EN != 0));
                acc_d   = '0;
                i_d     = '0;
                o_d     = (o_q == OW'(N_OUT - 1)) ? o_q : o_q + 1'b1;
                state_d = (o_q == OW'(N_OUT - 1)) ? OUT : MAC;
            end
            OUT: begin
                // out_valid is registered, so it trails entry into OUT by one cycle.
                out_valid_d = !(out_valid_q && out_ready);
                state_d     = (out_valid_q && out_ready) ? IDLE : OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '{default: '0};
            acc_q       <= '0;
            i_q         <= '0;
            o_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            o_q         <= o_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign busy         = state_q == MAC || state_q == FIN;
    assign out_valid    = out_valid_q;
    assign final_output = out_q;
    assign cfg_err      = cfg_err_q;

endmodule
